disp_arbiter: RTL and testbench
===============================

# disp_arbiter

Shares the 4-digit seven-segment display between the always-on score value and one-shot game messages, such as "PASS"/"FAIL" codes and round numbers. It sits directly upstream of the digit-scanning mux, driving its D/C/B/A nibbles plus a per-digit blank mask. A message is accepted through a req/ack handshake, shown for a fixed hold time (optionally blinking) and then released, after which the score returns to the display.

## Interface
- TICK_DIV, 1000000 — clk cycles per tick (10 ms at 100 MHz); legal range ≥ 2
- HOLD_TICKS, 50 — ticks a message stays on the display; legal range ≥ 1
- BLINK_TICKS, 25 — ticks per blink half-period; legal range ≥ 1
- clk  in  1  system clock; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- score  in  16  background value; [15:12] goes to D, [3:0] goes to A
- msg_req  in  1  message request; held high until acked
- msg_data  in  16  message nibbles, same packing as score; sampled on accept
- msg_blink  in  1  blink enable for this message; sampled on accept
- msg_abort  in  1  cancels the message currently shown
- msg_ack  out  1  one-cycle pulse: request accepted
- D, C, B, A  out  4 each  digit values to the scan mux (registered)
- blank  out  4  per-digit blank; 1 = digit off; bit 3 = D, bit 0 = A (registered)
- busy  out  1  high while in SHOW

## Operation
- Two states: IDLE and SHOW.
- **IDLE** behaviour:
  - {D,C,B,A} <= score every cycle.
  - blank <= 4'b0000.
- **IDLE → SHOW** on msg_req=1:
  - msg_data is latched and drives the outputs.
  - msg_blink is latched.
  - msg_ack=1 for exactly one cycle.
  - Tick counter and hold counter are cleared.
- **SHOW** behaviour:
  - Tick counter counts 0..TICK_DIV-1 and wraps; each wrap is a tick.
  - Hold counter increments on each tick.
  - The state leaves SHOW on the tick that brings the hold counter to HOLD_TICKS.
- **Blink** (latched msg_blink=1):
  - blank starts at 4'b0000 and toggles between 4'b0000 and 4'b1111 every BLINK_TICKS ticks, counted from entry.
  - With latched msg_blink=0, blank stays 4'b0000.
- **msg_abort** in SHOW → IDLE on the next edge; no ack is produced. msg_abort in IDLE is ignored.
- **Requests during SHOW** are not acked. The requester keeps msg_req high and is accepted in the first IDLE cycle.
- **Simultaneous events:**
  - Hold expiry and abort in the same cycle → IDLE (single transition).
  - msg_req concurrent with expiry or abort → not accepted that cycle. At least one IDLE cycle always separates two messages, so the score is visible for ≥1 cycle.
- **Width rules:**
  - Tick counter is clog2(TICK_DIV) bits.
  - Hold counter is clog2(HOLD_TICKS+1) bits.
  - Blink counter is clog2(BLINK_TICKS+1) bits.
  - No counter may overflow inside its legal range.

## Timing
- **Reset values:**
  - state = IDLE, msg_ack = 0, busy = 0.
  - D = C = B = A = 4'h0, blank = 4'b0000.
  - All counters = 0.
  - Reset takes effect immediately, including mid-SHOW. On release, the unit resumes in IDLE with no ack pending.
- **Accept:** msg_req sampled high in IDLE at edge t, so on the cycle after t:
  - msg_ack = 1, busy = 1.
  - Outputs show msg_data (value sampled at t).
  - msg_ack returns to 0 after edge t+1.
- **Hold duration:** the message is displayed for exactly HOLD_TICKS*TICK_DIV cycles. After that, outputs show score (registered, 1-cycle latency) and busy = 0.
- **Score latency:** in IDLE, a change on score appears on D..A one cycle later.
- **Abort:** msg_abort sampled at edge t → IDLE outputs on the cycle after t.
- **Data stability:** msg_data changes after accept do not affect the display.

## Test plan
- **Reset/idle:** assert rst_n=0 mid-cycle → all outputs at reset values immediately. Release, then set score=16'h1234 → D=1, C=2, B=3, A=4 one cycle later, blank=0000.
- **Accept and hold** (TICK_DIV=4, HOLD_TICKS=3): msg_req with msg_data=16'hFA11 → one msg_ack pulse; D..A=F,A,1,1 for exactly 12 cycles; then score is restored and busy falls.
- **Blink** (TICK_DIV=4, HOLD_TICKS=4, BLINK_TICKS=1): request with msg_blink=1 → blank = 0000, 1111, 0000, 1111 over 4-cycle windows, then 0000 in IDLE.
- **Back-to-back requests:** keep msg_req high across the end of a message →
  - second ack arrives ≥2 cycles after SHOW exits (one IDLE cycle shows score);
  - the second message's data is displayed.
- **Abort:** pulse msg_abort at cycle 5 of SHOW → score displayed the next cycle. Abort in IDLE → no effect. Abort coincident with expiry → single return to IDLE.
- **Reset mid-SHOW:** rst_n low during a blinking message → immediate reset values; after release, state is IDLE, no spurious ack, and score is shown.

Source files
------------

// File: rtl/disp_arbiter.sv
// Arbitrates the 4-digit display between the live score and one-shot messages.
// Messages are accepted by req/ack, held for HOLD_TICKS ticks (optionally blinking), then released.
module disp_arbiter #(
  parameter int TICK_DIV    = 1000000,
  parameter int HOLD_TICKS  = 50,
  parameter int BLINK_TICKS = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] score,
  input  logic        msg_req,
  input  logic [15:0] msg_data,
  input  logic        msg_blink,
  input  logic        msg_abort,
  output logic        msg_ack,
  output logic [3:0]  D,
  output logic [3:0]  C,
  output logic [3:0]  B,
  output logic [3:0]  A,
  output logic [3:0]  blank,
  output logic        busy
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  typedef enum logic {IDLE, SHOW} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_en_q, blink_en_d;
  logic [15:0]   disp_q, disp_d;
  logic [3:0]    blank_q, blank_d;
  logic          ack_q, ack_d;
  logic          tick_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      hold_q      <= '0;
      blink_cnt_q <= '0;
      blink_en_q  <= 1'b0;
      disp_q      <= '0;
      blank_q     <= '0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      hold_q      <= hold_d;
      blink_cnt_q <= blink_cnt_d;
      blink_en_q  <= blink_en_d;
      disp_q      <= disp_d;
      blank_q     <= blank_d;
      ack_q       <= ack_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    hold_d      = hold_q;
    blink_cnt_d = blink_cnt_q;
    blink_en_d  = blink_en_q;
    disp_d      = disp_q;
    blank_d     = blank_q;
    ack_d       = 1'b0;
    tick_wrap   = 1'b0;

    case (state_q)
      IDLE: begin
        disp_d      = score;
        blank_d     = 4'b0000;
        tick_d      = '0;
        hold_d      = '0;
        blink_cnt_d = '0;
        if (msg_req) begin
          state_d    = SHOW;
          disp_d     = msg_data;
          blink_en_d = msg_blink;
          ack_d      = 1'b1;
        end
      end

      SHOW: begin
        tick_wrap = (tick_q == TICK_LAST);
        tick_d    = tick_wrap ? '0 : tick_q + 1'b1;
        if (tick_wrap) begin
          hold_d = hold_q + 1'b1;
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            if (blink_en_q) blank_d = ~blank_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
        // Abort and expiry collapse into one exit; score is loaded so it shows next cycle.
        if (msg_abort || (tick_wrap && hold_q == HOLD_LAST)) begin
          state_d     = IDLE;
          disp_d      = score;
          blank_d     = 4'b0000;
          tick_d      = '0;
          hold_d      = '0;
          blink_cnt_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign {D, C, B, A} = disp_q;
  assign blank        = blank_q;
  assign msg_ack      = ack_q;
  assign busy         = (state_q == SHOW);

endmodule

// File: tb/tb_disp_arbiter.sv
// Bench for disp_arbiter: directed scenarios plus random traffic, checked against
// a time-based model (elapsed cycles since accept) rather than counters.
module tb_disp_arbiter;

  localparam int unsigned TD = 4;
  localparam int unsigned HT = 3;
  localparam int unsigned BT = 1;

  logic        clk;
  logic        rst_n;
  logic [15:0] score;
  logic        msg_req;
  logic [15:0] msg_data;
  logic        msg_blink;
  logic        msg_abort;
  logic        msg_ack;
  logic [3:0]  D, C, B, A;
  logic [3:0]  blank;
  logic        busy;

  int total = 0;
  int bad   = 0;

  disp_arbiter #(.TICK_DIV(TD), .HOLD_TICKS(HT), .BLINK_TICKS(BT)) dut (
    .clk(clk), .rst_n(rst_n), .score(score), .msg_req(msg_req), .msg_data(msg_data),
    .msg_blink(msg_blink), .msg_abort(msg_abort), .msg_ack(msg_ack),
    .D(D), .C(C), .B(B), .A(A), .blank(blank), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [15:0] disp    = {D, C, B, A};
  wire [21:0] dut_vec = {D, C, B, A, blank, msg_ack, busy};

  // Reference model: a message is visible for HT*TD cycles after its accept edge;
  // blank is on in odd BT*TD-cycle windows of that interval.
  int unsigned cyc = 0;
  int unsigned m_start = 0;
  logic        m_busy = 1'b0;
  logic        m_ack = 1'b0;
  logic        m_blink = 1'b0;
  logic [15:0] m_data = '0;
  logic [15:0] m_disp = '0;
  logic [3:0]  m_blank = '0;
  wire  [21:0] m_vec = {m_disp, m_blank, m_ack, m_busy};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0; m_start <= 0; m_busy <= 1'b0; m_ack <= 1'b0;
      m_disp <= '0; m_blank <= '0;
    end else begin
      cyc   <= cyc + 1;
      m_ack <= 1'b0;
      if (m_busy) begin
        if (msg_abort || (cyc + 1 - m_start) == HT * TD) begin
          m_busy <= 1'b0; m_disp <= score; m_blank <= 4'h0;
        end else begin
          m_disp  <= m_data;
          m_blank <= (m_blink && (((cyc + 1 - m_start) / (BT * TD)) % 2 == 1)) ? 4'hF : 4'h0;
        end
      end else if (msg_req) begin
        m_busy <= 1'b1; m_start <= cyc + 1; m_data <= msg_data; m_blink <= msg_blink;
        m_disp <= msg_data; m_ack <= 1'b1; m_blank <= 4'h0;
      end else begin
        m_disp <= score; m_blank <= 4'h0;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; msg_req = 1'b0; msg_data = '0; msg_blink = 1'b0; msg_abort = 1'b0;
    score = 16'h0;
    #1;
    total++;
    if (dut_vec !== 22'd0) begin bad++; $display("FAIL reset_initial got=%h exp=0", dut_vec); end
    @(negedge clk); rst_n = 1'b1; score = 16'hBEEF;
    @(negedge clk);
    total++;
    if (dut_vec !== m_vec) begin bad++; $display("FAIL reset_idle got=%h exp=%h", dut_vec, m_vec); end
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    total++;
    if (dut_vec !== 22'd0) begin bad++; $display("FAIL reset_async got=%h exp=0", dut_vec); end
    @(negedge clk); rst_n = 1'b1; score = 16'h1234;
    @(negedge clk);
    total++;
    if (disp !== 16'h1234 || blank !== 4'h0) begin
      bad++; $display("FAIL reset_score got=%h/%h exp=1234/0", disp, blank);
    end
  endtask

  task automatic test_accept();
    int acks = 0;
    int shown = 0;
    score = 16'h0ACE; msg_data = 16'hFA11; msg_blink = 1'b0; msg_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== m_vec) begin bad++; $display("FAIL accept_cyc%0d got=%h exp=%h", i, dut_vec, m_vec); end
      if (msg_ack) begin acks++; msg_req = 1'b0; end
      if (busy && disp == 16'hFA11) shown++;
      if (acks > 0) begin msg_data = 16'($urandom); score = 16'($urandom); end
    end
    total++;
    if (acks !== 1) begin bad++; $display("FAIL accept_ack_count got=%0d exp=1", acks); end
    total++;
    if (shown !== int'(HT * TD)) begin bad++; $display("FAIL accept_hold got=%0d exp=%0d", shown, HT * TD); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL accept_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_blink();
    int idx = -1;
    int on = 0;
    int first_on = -1;
    int exp_on = 0;
    msg_data = 16'($urandom); msg_blink = 1'b1; msg_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== m_vec) begin bad++; $display("FAIL blink_cyc%0d got=%h exp=%h", i, dut_vec, m_vec); end
      if (msg_ack) begin idx = 0; msg_req = 1'b0; end
      else if (idx >= 0) idx++;
      if (busy && blank == 4'hF) begin on++; if (first_on < 0) first_on = idx; end
    end
    msg_blink = 1'b0;
    for (int k = 0; k < int'(HT * TD); k++) if (((k / int'(BT * TD)) % 2) == 1) exp_on++;
    total++;
    if (on !== exp_on) begin bad++; $display("FAIL blink_on_cycles got=%0d exp=%0d", on, exp_on); end
    total++;
    if (first_on !== int'(BT * TD)) begin bad++; $display("FAIL blink_first_on got=%0d exp=%0d", first_on, BT * TD); end
    total++;
    if (blank !== 4'h0) begin bad++; $display("FAIL blink_idle_blank got=%h exp=0", blank); end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    int ack2 = -1;
    int first_idle = -1;
    score = 16'h5C0E; msg_data = 16'hA1A1; msg_blink = 1'b0; msg_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== m_vec) begin bad++; $display("FAIL b2b_cyc%0d got=%h exp=%h", i, dut_vec, m_vec); end
      if (msg_ack) begin
        acks++;
        if (acks == 1) msg_data = 16'hB2B2;
        else begin
          ack2 = i; msg_req = 1'b0;
          total++;
          if (disp !== 16'hB2B2) begin bad++; $display("FAIL b2b_second_data got=%h exp=b2b2", disp); end
        end
      end else if (acks == 1 && !busy && first_idle < 0) begin
        first_idle = i;
        total++;
        if (disp !== 16'h5C0E) begin bad++; $display("FAIL b2b_gap_score got=%h exp=5c0e", disp); end
      end
    end
    total++;
    if (acks !== 2) begin bad++; $display("FAIL b2b_ack_count got=%0d exp=2", acks); end
    total++;
    if (ack2 - first_idle !== 1) begin bad++; $display("FAIL b2b_gap got=%0d exp=1", ack2 - first_idle); end
  endtask

  task automatic test_abort();
    int idx = -1;
    score = 16'h7777; msg_data = 16'h1357; msg_blink = 1'($urandom); msg_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== m_vec) begin bad++; $display("FAIL abort_cyc%0d got=%h exp=%h", i, dut_vec, m_vec); end
      if (msg_ack) begin idx = 0; msg_req = 1'b0; end
      else if (idx >= 0) idx++;
      if (idx == 5) begin
        total++;
        if (busy !== 1'b0 || disp !== 16'h7777) begin
          bad++; $display("FAIL abort_exit got=%b/%h exp=0/7777", busy, disp);
        end
      end
      msg_abort = (idx == 4);
    end
    msg_abort = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== m_vec || busy !== 1'b0) begin
        bad++; $display("FAIL abort_idle_cyc%0d got=%h exp=%h", i, dut_vec, m_vec);
      end
    end
    msg_req = 1'b1; msg_data = 16'h9abc;
    @(negedge clk);
    total++;
    if (msg_ack !== 1'b1 || disp !== 16'h9abc) begin
      bad++; $display("FAIL abort_idle_accept got=%b/%h exp=1/9abc", msg_ack, disp);
    end
    msg_abort = 1'b0; msg_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== m_vec) begin bad++; $display("FAIL abort_run_cyc%0d got=%h exp=%h", i, dut_vec, m_vec); end
    end
    idx = -1; msg_req = 1'b1; msg_data = 16'h2468;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== m_vec) begin bad++; $display("FAIL coinc_cyc%0d got=%h exp=%h", i, dut_vec, m_vec); end
      if (idx < 0 && msg_ack) begin idx = 0; msg_req = 1'b0; end
      else if (idx >= 0) idx++;
      if (idx == int'(HT * TD)) begin
        total++;
        if (busy !== 1'b0 || msg_ack !== 1'b0) begin
          bad++; $display("FAIL coinc_exit got=busy%b/ack%b exp=0/0", busy, msg_ack);
        end
        msg_abort = 1'b0;
      end
      if (idx == int'(HT * TD) + 1) begin
        total++;
        if (msg_ack !== 1'b1) begin bad++; $display("FAIL coinc_reaccept got=%b exp=1", msg_ack); end
        msg_req = 1'b0;
      end
      if (idx == int'(HT * TD) - 1) begin msg_abort = 1'b1; msg_req = 1'b1; end
    end
  endtask

  task automatic test_reset_mid_show();
    logic found = 1'b0;
    msg_data = 16'($urandom); msg_blink = 1'b1; msg_req = 1'b1; msg_abort = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== m_vec) begin bad++; $display("FAIL rstshow_cyc%0d got=%h exp=%h", i, dut_vec, m_vec); end
      if (msg_ack) msg_req = 1'b0;
      if (busy && blank == 4'hF) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL rstshow_timeout got=no_blink exp=blink_on"); end
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    total++;
    if (dut_vec !== 22'd0) begin bad++; $display("FAIL rstshow_async got=%h exp=0", dut_vec); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; score = 16'h4321;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== m_vec || msg_ack !== 1'b0 || busy !== 1'b0 || disp !== 16'h4321) begin
        bad++; $display("FAIL rstshow_release_cyc%0d got=%h exp=%h", i, dut_vec, m_vec);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== m_vec) begin bad++; $display("FAIL rand_cyc%0d got=%h exp=%h", i, dut_vec, m_vec); end
      if (msg_ack) msg_req = 1'b0;
      else if (!msg_req && $urandom_range(0, 9) == 0) begin
        msg_req = 1'b1; msg_data = 16'($urandom); msg_blink = 1'($urandom_range(0, 1));
      end
      msg_abort = ($urandom_range(0, 29) == 0);
      score = 16'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_blink();
    test_back_to_back();
    test_abort();
    test_reset_mid_show();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
